// File: rtl/epass_if.sv
// Lane-side bundle between the gate controller / tag reader / top-up port and the E-pass checker.
// The master drives strobes and ids; the slave returns the verdict and its bookkeeping values.
interface epass_if #(
   parameter int TIME_W = 16,
   parameter int BAL_W  = 16,
   parameter int TAG_W  = 4
) ();
   logic              init;
   logic              count;
   logic              cal;
   logic              tag_valid;
   logic [TAG_W-1:0]  tag_id;
   logic              topup_en;
   logic [TAG_W-1:0]  topup_id;
   logic [BAL_W-1:0]  topup_amt;
   logic [1:0]        valid_Epass;
   logic [BAL_W-1:0]  fee;
   logic [BAL_W-1:0]  balance_out;
   logic [TIME_W-1:0] travel_time;
   logic              overspeed;
   logic              busy;

   modport master (
      output init, count, cal, tag_valid, tag_id, topup_en, topup_id, topup_amt,
      input  valid_Epass, fee, balance_out, travel_time, overspeed, busy
   );

   modport slave (
      input  init, count, cal, tag_valid, tag_id, topup_en, topup_id, topup_amt,
      output valid_Epass, fee, balance_out, travel_time, overspeed, busy
   );
endinterface

// File: rtl/epass_checker.sv
// Toll-lane E-pass checker: times a vehicle, latches its tag and charges a speed-dependent
// fee against a per-tag balance table, returning pass/reject on valid_Epass.
module epass_checker #(
   parameter int TIME_W   = 16,
   parameter int BAL_W    = 16,
   parameter int TAG_W    = 4,
   parameter int MIN_TIME = 50,
   parameter int FEE_BASE = 10,
   parameter int FEE_FAST = 20,
   parameter int INIT_BAL = 100
) (
   input  logic   clk,
   input  logic   reset_n,
   epass_if.slave bus
);
   localparam int NACC = 2**TAG_W;

   typedef enum logic [1:0] {IDLE, LOOKUP, DECIDE, RESULT} state_t;

   function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] a,
                                                input logic [BAL_W-1:0] b);
      logic [BAL_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[BAL_W] ? {BAL_W{1'b1}} : s[BAL_W-1:0];
   endfunction

   function automatic logic [BAL_W-1:0] fee_for(input logic [TIME_W-1:0] t);
      return (t < TIME_W'(MIN_TIME)) ? BAL_W'(FEE_FAST) : BAL_W'(FEE_BASE);
   endfunction

   state_t            state, state_nxt;
   logic              cal_q;
   logic [TIME_W-1:0] timer;
   logic              tag_ok;
   logic [TAG_W-1:0]  tag_r;
   logic [BAL_W-1:0]  balance [NACC];

   logic [TAG_W-1:0]  tag_p0;
   logic              tag_ok_p0;
   logic [TIME_W-1:0] time_p0;
   logic [BAL_W-1:0]  bal_p1;
   logic              pass_p2;
   logic              fast_p2;
   logic [BAL_W-1:0]  fee_p2;
   logic [BAL_W-1:0]  post_p2;

   logic [1:0]        valid_q;
   logic [BAL_W-1:0]  fee_q;
   logic [BAL_W-1:0]  bal_q;
   logic              fast_q;

   logic              start;
   logic [BAL_W-1:0]  fee_d;
   logic              ok_d;
   logic              charge;

   assign start  = (state == IDLE) && bus.cal && !cal_q;
   assign fee_d  = fee_for(time_p0);
   assign ok_d   = tag_ok_p0 && (bal_p1 >= fee_d);
   assign charge = (state == DECIDE) && bus.cal && ok_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cal_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cal_q <= bus.cal;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOOKUP;
         LOOKUP:  state_nxt = bus.cal ? DECIDE : IDLE;
         DECIDE:  state_nxt = bus.cal ? RESULT : IDLE;
         RESULT:  if (!bus.cal) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Timer and tag capture run independently of the FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer  <= '0;
         tag_ok <= 1'b0;
         tag_r  <= '0;
      end else begin
         if (bus.init)
            timer <= '0;
         else if (bus.count && (timer != {TIME_W{1'b1}}))
            timer <= timer + TIME_W'(1);
         if (bus.init) begin
            tag_ok <= bus.tag_valid;
            tag_r  <= bus.tag_valid ? bus.tag_id : '0;
         end else if (bus.count && bus.tag_valid && !tag_ok) begin
            tag_ok <= 1'b1;
            tag_r  <= bus.tag_id;
         end
      end
   end

   // p0: snapshot on the cal edge; p1: balance read; p2: verdict
   always_ff @(posedge clk) begin
      if (start) begin
         tag_p0    <= tag_r;
         tag_ok_p0 <= tag_ok;
         time_p0   <= timer;
      end
      if (state == LOOKUP)
         bal_p1 <= (bus.topup_en && (bus.topup_id == tag_p0)) ?
                   sat_add(balance[tag_p0], bus.topup_amt) : balance[tag_p0];
      if (state == DECIDE) begin
         pass_p2 <= ok_d;
         fast_p2 <= (time_p0 < TIME_W'(MIN_TIME));
         fee_p2  <= fee_d;
         post_p2 <= ok_d ? (bal_p1 - fee_d) : bal_p1;
      end
   end

   // A top-up colliding with the charge is merged into the single write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NACC; i++) balance[i] <= BAL_W'(INIT_BAL);
      end else begin
         for (int i = 0; i < NACC; i++) begin
            if (charge && (tag_p0 == TAG_W'(i)))
               balance[i] <= sat_add(bal_p1 - fee_d,
                  (bus.topup_en && (bus.topup_id == TAG_W'(i))) ? bus.topup_amt : '0);
            else if (bus.topup_en && (bus.topup_id == TAG_W'(i)))
               balance[i] <= sat_add(balance[i], bus.topup_amt);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 2'b00;
         fee_q   <= '0;
         bal_q   <= '0;
         fast_q  <= 1'b0;
      end else if (state == RESULT) begin
         if (bus.cal) begin
            valid_q <= pass_p2 ? 2'b10 : 2'b01;
            fee_q   <= fee_p2;
            bal_q   <= post_p2;
            fast_q  <= fast_p2;
         end else begin
            valid_q <= 2'b00;
         end
      end
   end

   assign bus.valid_Epass = valid_q;
   assign bus.fee         = fee_q;
   assign bus.balance_out = bal_q;
   assign bus.overspeed   = fast_q;
   assign bus.travel_time = timer;
   assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_epass_checker.sv
// Randomized bench for epass_checker: a balance-table model predicts each verdict, fee and
// post-charge balance from the fee rules, independent of the RTL's pipeline.
module tb_epass_checker;
   localparam int TIME_W = 16;
   localparam int BAL_W  = 16;
   localparam int TAG_W  = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b1;

   epass_if #(.TIME_W(TIME_W), .BAL_W(BAL_W), .TAG_W(TAG_W)) bus ();

   epass_checker #(.TIME_W(TIME_W), .BAL_W(BAL_W), .TAG_W(TAG_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int bal_m [16];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.init = 0; bus.count = 0; bus.cal = 0; bus.tag_valid = 0; bus.tag_id = '0;
      bus.topup_en = 0; bus.topup_id = '0; bus.topup_amt = '0;
   endtask

   function automatic int exp_fee(int t);
      return (t < 50) ? 20 : 10;
   endfunction

   function automatic int sat16(int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) bal_m[i] = 100;
   endtask

   task automatic do_topup(input int id, input int amt);
      bus.topup_en = 1; bus.topup_id = TAG_W'(id); bus.topup_amt = BAL_W'(amt);
      tick();
      bus.topup_en = 0;
      bal_m[id] = sat16(bal_m[id] + amt);
   endtask

   task automatic run_vehicle(input int tag, input bit has_tag, input int ncnt, input bit col,
                              input int camt, input int hold, input bit chk_bo);
      int fee_e, pre;
      bit ok;
      logic [1:0] v_e;
      bus.init = 1; tick(); bus.init = 0;
      bus.count = 1;
      for (int c = 0; c < ncnt; c++) begin
         bus.tag_valid = has_tag && (c == 0 || c == ncnt / 2);
         bus.tag_id    = (c == 0) ? TAG_W'(tag) : TAG_W'(tag ^ 1);
         tick();
      end
      bus.count = 0; bus.tag_valid = 0;
      n_total++;
      if (bus.travel_time !== TIME_W'(ncnt))
         $display("FAIL travel_time: got %0d want %0d", bus.travel_time, ncnt);
      else n_pass++;
      fee_e = exp_fee(ncnt);
      pre   = bal_m[tag];
      ok    = has_tag && (pre >= fee_e);
      v_e   = ok ? 2'b10 : 2'b01;
      bus.cal = 1;
      tick();
      n_total++;
      if (bus.valid_Epass !== 2'b00 || bus.busy !== 1'b1)
         $display("FAIL latency_n: valid=%b busy=%b want 00/1", bus.valid_Epass, bus.busy);
      else n_pass++;
      tick();
      if (col) begin
         bus.topup_en = 1; bus.topup_id = TAG_W'(tag); bus.topup_amt = BAL_W'(camt);
      end
      tick();
      bus.topup_en = 0;
      n_total++;
      if (bus.valid_Epass !== 2'b00)
         $display("FAIL latency_n2: valid=%b want 00", bus.valid_Epass);
      else n_pass++;
      tick();
      n_total++;
      if (bus.valid_Epass !== v_e)
         $display("FAIL verdict tag %0d: got %b want %b", tag, bus.valid_Epass, v_e);
      else n_pass++;
      n_total++;
      if (bus.fee !== BAL_W'(fee_e) || bus.overspeed !== (ncnt < 50))
         $display("FAIL fee/overspeed: got %0d/%b want %0d/%b", bus.fee, bus.overspeed,
                  fee_e, (ncnt < 50));
      else n_pass++;
      if (chk_bo) begin
         n_total++;
         if (bus.balance_out !== BAL_W'(ok ? pre - fee_e : pre))
            $display("FAIL balance_out tag %0d: got %0d want %0d", tag, bus.balance_out,
                     ok ? pre - fee_e : pre);
         else n_pass++;
      end
      if (ok) bal_m[tag] = pre - fee_e;
      if (col) bal_m[tag] = sat16(bal_m[tag] + camt);
      for (int h = 1; h < hold; h++) begin
         tick();
         n_total++;
         if (bus.valid_Epass !== v_e)
            $display("FAIL verdict_hold: got %b want %b", bus.valid_Epass, v_e);
         else n_pass++;
      end
      bus.cal = 0;
      tick();
      n_total++;
      if (bus.valid_Epass !== 2'b00 || bus.busy !== 1'b0)
         $display("FAIL release: valid=%b busy=%b want 00/0", bus.valid_Epass, bus.busy);
      else n_pass++;
   endtask

   task automatic test_reset();
      idle_inputs();
      #2 reset_n = 0;
      #1;
      n_total++;
      if (bus.valid_Epass !== 2'b00 || bus.fee !== '0 || bus.balance_out !== '0 ||
          bus.travel_time !== '0 || bus.overspeed !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL reset_outputs: valid=%b fee=%0d bal=%0d time=%0d ovs=%b busy=%b want all 0",
                  bus.valid_Epass, bus.fee, bus.balance_out, bus.travel_time, bus.overspeed, bus.busy);
      else n_pass++;
      model_reset();
      @(negedge clk) reset_n = 1;
      tick();
   endtask

   task automatic test_normal();
      run_vehicle(3, 1, 100, 0, 0, 1, 1);
   endtask

   task automatic test_overspeed();
      run_vehicle(5, 1, 20, 0, 0, 2, 1);
   endtask

   task automatic test_low_balance();
      do_topup(7, 5);
      for (int k = 0; k < 5; k++) run_vehicle(7, 1, 20, 0, 0, 1, 1);
      run_vehicle(7, 1, 100, 0, 0, 1, 1);
      do_topup(7, 20);
      run_vehicle(7, 1, 100, 0, 0, 1, 1);
   endtask

   task automatic test_no_tag();
      run_vehicle(9, 0, 100, 0, 0, 10, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         n_total++;
         if (bus.valid_Epass !== 2'b00)
            $display("FAIL single_verdict: got %b want 00", bus.valid_Epass);
         else n_pass++;
      end
      run_vehicle(9, 1, 100, 0, 0, 1, 1);
      run_vehicle(0, 1, 100, 0, 0, 1, 1);
   endtask

   task automatic test_collision();
      run_vehicle(2, 1, 100, 1, 50, 1, 0);
      run_vehicle(2, 1, 100, 0, 0, 1, 1);
      do_topup(2, 16'hFFFF);
      run_vehicle(2, 1, 100, 0, 0, 1, 1);
   endtask

   task automatic test_abort_lookup();
      bus.init = 1; tick(); bus.init = 0;
      bus.count = 1; bus.tag_valid = 1; bus.tag_id = 4'd4; tick(); bus.tag_valid = 0;
      for (int c = 1; c < 100; c++) tick();
      bus.count = 0;
      bus.cal = 1; tick();
      bus.cal = 0; tick();
      n_total++;
      if (bus.valid_Epass !== 2'b00 || bus.busy !== 1'b0)
         $display("FAIL abort_lookup: valid=%b busy=%b want 00/0", bus.valid_Epass, bus.busy);
      else n_pass++;
      for (int k = 0; k < 3; k++) tick();
      run_vehicle(4, 1, 100, 0, 0, 1, 1);
   endtask

   task automatic test_reset_in_result();
      bus.init = 1; tick(); bus.init = 0;
      bus.count = 1; bus.tag_valid = 1; bus.tag_id = 4'd6; tick(); bus.tag_valid = 0;
      for (int c = 1; c < 60; c++) tick();
      bus.count = 0;
      bus.cal = 1;
      for (int k = 0; k < 4; k++) tick();
      n_total++;
      if (bus.valid_Epass !== ((bal_m[6] >= 10) ? 2'b10 : 2'b01))
         $display("FAIL pre_reset_verdict: got %b want %b", bus.valid_Epass,
                  (bal_m[6] >= 10) ? 2'b10 : 2'b01);
      else n_pass++;
      reset_n = 0;
      #1;
      n_total++;
      if (bus.valid_Epass !== 2'b00 || bus.fee !== '0 || bus.balance_out !== '0 ||
          bus.busy !== 1'b0 || bus.travel_time !== '0)
         $display("FAIL reset_in_result: valid=%b fee=%0d bal=%0d busy=%b want 0",
                  bus.valid_Epass, bus.fee, bus.balance_out, bus.busy);
      else n_pass++;
      bus.cal = 0;
      model_reset();
      @(negedge clk) reset_n = 1;
      tick();
      run_vehicle(6, 1, 100, 0, 0, 1, 1);
      run_vehicle(3, 1, 100, 0, 0, 1, 1);
   endtask

   task automatic test_random();
      for (int it = 0; it < 12; it++) begin
         int tag, ncnt, camt, hold;
         bit has_tag, col;
         if ($urandom_range(0, 1) == 1) do_topup($urandom_range(0, 15), $urandom_range(0, 50));
         tag     = $urandom_range(0, 15);
         has_tag = ($urandom_range(0, 7) != 0);
         ncnt    = $urandom_range(5, 120);
         col     = ($urandom_range(0, 3) == 0);
         camt    = $urandom_range(0, 300);
         hold    = $urandom_range(1, 4);
         run_vehicle(tag, has_tag, ncnt, col, camt, hold, has_tag && !col);
      end
   endtask

   initial begin
      idle_inputs();
      model_reset();
      test_reset();
      test_normal();
      test_overspeed();
      test_low_balance();
      test_no_tag();
      test_collision();
      test_abort_lookup();
      test_reset_in_result();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
